// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered mux/arbiter family.
package mux_pkg;

  localparam logic ARB_MODE_SEL = 1'b0;
  localparam logic ARB_MODE_RR  = 1'b1;

  // Round-robin successor with wrap from n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_grant_n.sv
// Combinational priority search over i_req starting at i_start, wrapping N-1 -> 0.
module rr_grant_n #(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_start,
  output logic [SELW-1:0] o_grant_idx,
  output logic            o_found
);

  always_comb begin
    o_grant_idx = '0;
    o_found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_found && i_req[SELW'((32'(i_start) + k) % N)]) begin
        o_found     = 1'b1;
        o_grant_idx = SELW'((32'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n_1.sv
// N-input registered mux with explicit-select or round-robin grant and valid/ready handshakes.
// Define MUX_ARB_PERF_EN to add the saturating output-transfer counter port perf_cnt.
module mux_arb_n_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 arb_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
`ifdef MUX_ARB_PERF_EN
  ,
  output logic [31:0]          perf_cnt
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic             w_grant_vld;
  logic             w_accept;
  logic             w_rr_found;
  logic [SELW-1:0]  w_rr_idx;
  logic [SELW-1:0]  w_grant_idx;
  logic [WIDTH-1:0] w_grant_data;

  rr_grant_n #(
    .N (N)
  ) u_rr_grant (
    .i_req       (in_valid),
    .i_start     (r_rr_ptr),
    .o_grant_idx (w_rr_idx),
    .o_found     (w_rr_found)
  );

  assign w_load_en = !r_out_valid || out_ready;

  // Select values >= N (non power-of-two N) never grant.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (arb_mode == ARB_MODE_RR) begin
      w_grant_vld = w_rr_found;
      w_grant_idx = w_rr_idx;
    end else if (32'(sel) < N) begin
      w_grant_vld = in_valid[sel];
      w_grant_idx = sel;
    end
  end

  assign w_accept     = w_load_en && w_grant_vld;
  assign w_grant_data = in_data[32'(w_grant_idx) * WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (rst_n && w_accept) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_chan  <= w_grant_idx;
      if (arb_mode == ARB_MODE_RR) begin
        r_rr_ptr <= SELW'(rr_next(32'(w_grant_idx), N));
      end
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

`ifdef MUX_ARB_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (r_out_valid && out_ready && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_mux_arb_n_1.sv
// Directed bench for mux_arb_n_1: a 4-channel and a 3-channel instance driven side by side.
module tb_mux_arb_n_1;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4*W-1:0] in_data4;
  logic [3:0]     in_valid4, in_ready4;
  logic [1:0]     sel4, out_chan4;
  logic           arb4, out_valid4, out_ready4;
  logic [W-1:0]   out_data4;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [1:0]     sel3, out_chan3;
  logic           arb3, out_valid3, out_ready3;
  logic [W-1:0]   out_data3;

`ifdef MUX_ARB_PERF_EN
  logic [31:0] perf4, perf3;
`endif

  int checks = 0;
  int errors = 0;

  mux_arb_n_1 #(.WIDTH(W), .N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .sel       (sel4),
    .arb_mode  (arb4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_chan  (out_chan4)
`ifdef MUX_ARB_PERF_EN
    ,
    .perf_cnt  (perf4)
`endif
  );

  mux_arb_n_1 #(.WIDTH(W), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .arb_mode  (arb3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_chan  (out_chan3)
`ifdef MUX_ARB_PERF_EN
    ,
    .perf_cnt  (perf3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [6];
    rr_exp = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    rst_n      = 1'b0;
    in_data4   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    in_valid4  = 4'b1111;
    sel4       = 2'd0;
    arb4       = 1'b0;
    out_ready4 = 1'b1;
    in_data3   = {32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    in_valid3  = 3'b111;
    sel3       = 2'd1;
    arb3       = 1'b0;
    out_ready3 = 1'b1;

    // Reset with every input valid.
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data", out_data4, 32'd0);
    chk("rst_out_chan", 32'(out_chan4), 32'd0);
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_in_ready3", 32'(in_ready3), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready4), 32'b0001);
    chk("post_rst_in_ready3", 32'(in_ready3), 32'b010);
    tick();
    chk("first_valid", 32'(out_valid4), 32'd1);
    chk("first_data", out_data4, 32'h1000_0000);
    chk("first_chan", 32'(out_chan4), 32'd0);
    chk("n3_first_chan", 32'(out_chan3), 32'd1);

    // Explicit select; N=3 instance gets out-of-range select.
    in_data4[2*W +: W] = 32'hDEAD_BEEF;
    sel4 = 2'd2;
    sel3 = 2'd3;
    #1;
    chk("sel_in_ready", 32'(in_ready4), 32'b0100);
    chk("oor_in_ready", 32'(in_ready3), 32'b000);
    tick();
    chk("sel_data", out_data4, 32'hDEAD_BEEF);
    chk("sel_chan", 32'(out_chan4), 32'd2);
    chk("oor_valid", 32'(out_valid3), 32'd0);
    chk("oor_data_hold", out_data3, 32'h2000_0001);
    chk("oor_chan_hold", 32'(out_chan3), 32'd1);

    // Backpressure on N=4 while N=3 round-robins through all channels.
    out_ready4 = 1'b0;
    sel4 = 2'd1;
    arb3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready4), 32'd0);
      tick();
      chk("bp_data", out_data4, 32'hDEAD_BEEF);
      chk("bp_chan", 32'(out_chan4), 32'd2);
      chk("bp_valid", 32'(out_valid4), 32'd1);
      chk("n3_rr_chan", 32'(out_chan3), 32'(i));
      chk("n3_rr_data", out_data3, 32'h2000_0000 + 32'(i));
    end
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready4), 32'b0010);
    tick();
    chk("bp_release_data", out_data4, 32'h1000_0001);
    chk("bp_release_chan", 32'(out_chan4), 32'd1);
    chk("bp_release_valid", 32'(out_valid4), 32'd1);
    chk("n3_rr_wrap", 32'(out_chan3), 32'd0);

    // Round robin on N=4; N=3 goes idle.
    arb4 = 1'b1;
    in_valid4 = 4'b1011;
    in_valid3 = 3'b000;
    #1;
    chk("rr_first_ready", 32'(in_ready4), 32'b0001);
    chk("n3_idle_ready", 32'(in_ready3), 32'd0);
    tick();
    chk("n3_idle_valid", 32'(out_valid3), 32'd0);
    chk("n3_idle_data", out_data3, 32'h2000_0000);
    chk("rr_seq0", 32'(out_chan4), 32'(rr_exp[0]));
    in_valid3 = 3'b101;
    #1;
    // Pointer is 1 after the last accept of ch0; the idle cycle must not move it.
    chk("n3_ptr_after_idle", 32'(in_ready3), 32'b100);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("rr_seq", 32'(out_chan4), 32'(rr_exp[i]));
      chk("rr_data", out_data4, 32'h1000_0000 + 32'(rr_exp[i]));
      if (i == 1) begin
        chk("n3_after_idle_chan", 32'(out_chan3), 32'd2);
      end
    end

    in_valid4 = 4'b0000;
    tick();
    chk("rr_idle_valid", 32'(out_valid4), 32'd0);
    chk("rr_idle_data", out_data4, 32'h1000_0003);
    chk("rr_idle_chan", 32'(out_chan4), 32'd3);
    in_valid4 = 4'b1111;
    #1;
    chk("rr_ptr_held", 32'(in_ready4), 32'b0001);
    arb4 = 1'b0;
    sel4 = 2'd2;
    #1;
    chk("mode_switch_ready", 32'(in_ready4), 32'b0100);

`ifdef MUX_ARB_PERF_EN
    rst_n = 1'b0;
    tick();
    chk("perf_rst", perf4, 32'd0);
    rst_n = 1'b1;
    sel4 = 2'd0;
    out_ready4 = 1'b1;
    tick();
    // 12 cycles with stalls at 3 and 8 give 10 output transfers.
    for (int i = 0; i < 12; i++) begin
      out_ready4 = !(i == 3 || i == 8);
      tick();
    end
    chk("perf_count", perf4, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_n_1.md
Name: mux_arb_n_1

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes:
  - explicit select, the successor to the plain select-driven muxes in the datapath;
  - round-robin arbitration, for sharing one downstream port (e.g. a memory or writeback bus) between several producers.
- One output register stage; sustains one transfer per cycle.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- sel  input  SELW  channel select, used when arb_mode=0.
- arb_mode  input  1  0 = explicit select, 1 = round-robin.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_chan=0;
  - round-robin pointer rr_ptr=0;
  - in_ready all 0 while rst_n=0.
- Reset mid-transfer drops the held word; no recovery.
- Load enable: load_en = !out_valid || out_ready.
- Grant (combinational, one-hot or none):
  - arb_mode=0: grant channel sel if sel<N and in_valid[sel]. sel>=N gives no grant.
  - arb_mode=1: grant the first i with in_valid[i], searching from rr_ptr upward and wrapping N-1 -> 0.
- Handshakes:
  - in_ready[i] = load_en && (i == granted index). Only the granted channel is ever ready.
  - A channel holding in_valid with no grant sees in_ready=0 and must hold its data.
- Input accept (in_valid[g] && in_ready[g]) on a clock edge:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1;
  - if arb_mode=1, rr_ptr <= (g+1) mod N.
- load_en=1 with no grant: out_valid <= 0. out_data and out_chan hold their values.
- load_en=0 (out_valid=1, out_ready=0): output registers and rr_ptr hold; all in_ready=0.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: back-to-back accepts while out_ready=1.
- Simultaneous output drain and new accept in the same cycle: the new word replaces the old one, with no bubble.
- rr_ptr updates only in arb_mode=1 and only on an accept.
- arb_mode or sel changes take effect in the same cycle's grant. They never disturb a word already in the output register.
- N not a power of two: indices >= N are unreachable in round-robin mode and rejected in select mode.

Optional Feature:
- Macro MUX_ARB_PERF_EN.
- Defined:
  - adds output port perf_cnt, 32 bits;
  - perf_cnt counts output transfers (out_valid && out_ready) and saturates at 32'hFFFF_FFFF;
  - reset value 0.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package mux_pkg:
  - ARB_MODE_SEL=1'b0, ARB_MODE_RR=1'b1;
  - helper function rr_next(ptr, N) implementing the wrap.
- Sub-module rr_grant_n: a combinational priority search from a start pointer, returning the grant index and a found flag. It is reusable by other arbiters.
- mux_arb_n_1 instantiates rr_grant_n and contains the output register, the handshake and rr_ptr.

Test Plan:
- Reset check: assert rst_n=0 with all inputs valid -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000. Deassert -> first accept occurs on the next edge.
- Select mode: arb_mode=0, sel=2, in_valid=4'b1111, ch2 data=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=32'hDEAD_BEEF, out_chan=2.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0. Raise out_ready -> new word loads in the same edge, with no bubble.
- Round robin: arb_mode=1, in_valid=4'b1011 held, out_ready=1 -> out_chan sequence 0,1,3,0,1,3.
- Out-of-range and idle, with N=3: sel=3 -> no grant, out_valid falls to 0. In round-robin mode with in_valid=0 -> out_valid=0 and rr_ptr unchanged.
- Perf counter (MUX_ARB_PERF_EN): 10 output transfers with 2 stall cycles interleaved -> perf_cnt=10. Preload near saturation -> perf_cnt holds at 32'hFFFF_FFFF.
